alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Keeps opcode encodings 0-4 and adds logical shifts, status flags and an optional multi-cycle multiplier.
- Uses a valid/ready handshake on both sides, so it can sit between a register-file read stage and a writeback stage.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
opcode  input  3  0 plus, 1 minus, 2 and, 3 or, 4 not-a, 5 shl, 6 shr, 7 mul
out_valid  output  1  result registered and held
out_ready  input  1  downstream consumes result
out  output  WIDTH  result
zero  output  1  out == 0
carry  output  1  add carry-out / subtract borrow / multiply high-part nonzero
ovf  output  1  two's-complement overflow (plus/minus only)
err  output  1  opcode not supported in this build

Behaviour:
- Clock and reset: one clock domain (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, out_valid=0, out=0, zero=0, carry=0, ovf=0, err=0, multiplier registers 0.
- in_ready is combinational: 1 in IDLE; 1 in DONE when out_ready=1; 0 in MUL, and 0 in DONE when out_ready=0.
- Accept: occurs on an edge where in_valid and in_ready are both 1. a, b and opcode are captured at that edge.
- States and transitions:
  - IDLE, accept of op 0-6 or unsupported 7 -> DONE, result registered at the accepting edge. Latency is 1 cycle.
  - IDLE, accept of op 7 with MUL_EN -> MUL, with multiplicand=a, multiplier=b, acc=0 and count=0.
  - MUL: one shift-add step per cycle, over WIDTH cycles. If multiplier LSB=1, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. The accumulator is 2*WIDTH bits wide.
  - MUL, after step WIDTH -> DONE, out=acc[WIDTH-1:0], carry=|acc[2W-1:W].
  - DONE, out_valid=1 and outputs are held stable until out_ready=1.
  - DONE with out_ready=1 and no new accept -> IDLE, out_valid=0.
  - DONE with out_ready=1 and a simultaneous accept -> handled exactly as from IDLE. There is no bubble for ops 0-6.
- Arithmetic rules:
  - plus: {carry,out} = a + b.
  - minus: out = a - b (mod 2^WIDTH), carry = (a < b unsigned).
  - ovf for plus: a and b have the same sign and out has a different sign. ovf for minus: a and b have different signs and out's sign differs from a.
  - and, or, not-a, shl, shr: carry=0, ovf=0.
  - shl/shr: shift is logical, amount = b[SHW-1:0], upper bits of b ignored, zero fill.
  - not-a ignores b.
  - zero is computed from the final out for every opcode, including mul.
  - err=0 for all supported ops.
- in_valid while in_ready=0 has no effect. The upstream must hold its operands until accepted.
- out_ready while out_valid=0 is ignored.
- rst asserted in any state, including mid-MUL, immediately returns to reset values. A partial product is discarded and never presented.
- No X outputs for any opcode.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: opcode 7 is the WIDTH-cycle shift-add multiplier described above, with latency WIDTH+1 cycles.
- Undefined: the MUL state and multiplier registers are not built. Opcode 7 goes straight to DONE in 1 cycle with out=0, zero=1, carry=0, ovf=0, err=1.

Test Plan:
- plus, a=8'hF0, b=8'h20, out_ready=1 -> next cycle out=8'h10, carry=1, ovf=0, zero=0, out_valid=1 for one cycle.
- minus, a=8'h80, b=8'h01 -> out=8'h7F, carry=0, ovf=1. Then minus, a=8'h01, b=8'h02 -> out=8'hFF, carry=1, ovf=0.
- not-a, a=8'hFF -> out=8'h00, zero=1. Then shl, a=8'h81, b=8'h0B (amount 3) -> out=8'h08. Then shr, a=8'h81, b=8'h07 -> out=8'h01.
- Backpressure: plus 1+2 with out_ready=0 for 3 cycles -> out=8'h03 held, in_ready=0, a second op presented is not accepted. Raise out_ready with the second op (or 4'h0F|8'hF0) valid -> accepted that edge, next cycle out=8'hFF, no idle cycle.
- With MUL_EN:
  - 20*13 -> out=8'h04, carry=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout MUL.
  - 13*11 -> out=8'h8F, carry=0.
  - rst pulsed at MUL cycle 4 -> out_valid stays 0, all outputs are 0, and the next op works normally.
- Without MUL_EN: opcode 7 with a=8'h05, b=8'h05 -> 1-cycle latency, out=0, zero=1, err=1. A following plus -> err=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
// The master side presents operations and consumes results.
// The slave side is the ALU itself.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             err;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, out, zero, carry, ovf, err
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, out, zero, carry, ovf, err
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake on both sides.
// Opcodes: 0 plus, 1 minus, 2 and, 3 or, 4 not-a, 5 shl, 6 shr, 7 mul.
// Optional feature macro ALU_PIPE_MUL_EN builds the WIDTH-cycle shift-add
// multiplier for opcode 7; without it opcode 7 completes in one cycle with err=1.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_PIPE_MUL_EN
   localparam logic [1:0]   S_MUL    = 2'd1;
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic             in_ready_s;
   logic             accept_s;
   logic [WIDTH-1:0] res_s;
   logic             carry_s;
   logic             ovf_s;
   logic             err_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   diff_s;

`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SHW:0]       cnt_q, cnt_d;
`endif

   // Signed overflow: operands (b already sign-adjusted for minus) agree, result sign differs.
   function automatic logic sign_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   assign in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;
   assign sum_s      = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_s     = {1'b0, bus.a} - {1'b0, bus.b};

   // Single-cycle datapath for the operation currently presented.
   always_comb begin
      res_s   = {WIDTH{1'b0}};
      carry_s = 1'b0;
      ovf_s   = 1'b0;
      err_s   = 1'b0;
      case (bus.opcode)
         3'd0: begin
            res_s   = sum_s[WIDTH-1:0];
            carry_s = sum_s[WIDTH];
            ovf_s   = sign_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum_s[WIDTH-1]);
         end
         3'd1: begin
            res_s   = diff_s[WIDTH-1:0];
            carry_s = diff_s[WIDTH];
            ovf_s   = sign_ovf(bus.a[WIDTH-1], ~bus.b[WIDTH-1], diff_s[WIDTH-1]);
         end
         3'd2:    res_s = bus.a & bus.b;
         3'd3:    res_s = bus.a | bus.b;
         3'd4:    res_s = ~bus.a;
         3'd5:    res_s = bus.a << bus.b[SHW-1:0];
         3'd6:    res_s = bus.a >> bus.b[SHW-1:0];
`ifdef ALU_PIPE_MUL_EN
         3'd7:    res_s = {WIDTH{1'b0}};
`else
         3'd7:    err_s = 1'b1;
`endif
         default: err_s = 1'b1;
      endcase
   end

   // Next-state logic: handshake sequencing, result capture and multiplier stepping.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
`ifdef ALU_PIPE_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
`ifdef ALU_PIPE_MUL_EN
         S_MUL: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               out_d   = acc_q[WIDTH-1:0];
               zero_d  = (acc_q[WIDTH-1:0] == {WIDTH{1'b0}});
               carry_d = |acc_q[2*WIDTH-1:WIDTH];
               ovf_d   = 1'b0;
               err_d   = 1'b0;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end else begin
                  acc_d = acc_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + {{SHW{1'b0}}, 1'b1};
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // A new accept overrides the DONE->IDLE drain so back-to-back ops have no bubble.
      if (accept_s) begin
`ifdef ALU_PIPE_MUL_EN
         if (bus.opcode == 3'd7) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = {2*WIDTH{1'b0}};
            cnt_d    = {(SHW+1){1'b0}};
         end else begin
            state_d = S_DONE;
            out_d   = res_s;
            zero_d  = (res_s == {WIDTH{1'b0}});
            carry_d = carry_s;
            ovf_d   = ovf_s;
            err_d   = err_s;
         end
`else
         state_d = S_DONE;
         out_d   = res_s;
         zero_d  = (res_s == {WIDTH{1'b0}});
         carry_d = carry_s;
         ovf_d   = ovf_s;
         err_d   = err_s;
`endif
      end else begin
         state_d = state_d;
      end
   end

   // Control state and registered result/flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         out_q   <= {WIDTH{1'b0}};
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

`ifdef ALU_PIPE_MUL_EN
   // Multiplier working registers; reset discards any partial product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= {2*WIDTH{1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         acc_q    <= {2*WIDTH{1'b0}};
         cnt_q    <= {(SHW+1){1'b0}};
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out       = out_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;
endmodule
